// File: rtl/wbu_arbiter_pkg.sv
// Shared widths, starvation limit and grant-source encoding for the write-back arbiter.
package wbu_arbiter_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int RFIDX_W_DEF    = 5;
    localparam int CSRIDX_W_DEF   = 12;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_MDU  = 2'd2,
        GNT_LSU  = 2'd3
    } gnt_src_e;

endpackage

// File: rtl/wbu_pend_slot.sv
// One-entry holding register for a result that lost write-port arbitration.
module wbu_pend_slot
    import wbu_arbiter_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RFIDX_W = RFIDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               kill,
    input  logic [RFIDX_W-1:0] load_idx,
    input  logic [XLEN-1:0]    load_data,
    output logic               vld,
    output logic [RFIDX_W-1:0] idx,
    output logic [XLEN-1:0]    data
);

    // A load wins over clear so a drained slot can be refilled in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            idx  <= '0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            idx  <= load_idx;
            data <= load_data;
        end else if (clear || kill) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/wbu_arbiter.sv
// Write-back arbiter: merges ALU, MDU and LSU results onto one register-file write port
// and registers the CSR write.
module wbu_arbiter
    import wbu_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RFIDX_W    = RFIDX_W_DEF,
    parameter int CSRIDX_W   = CSRIDX_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rdwen0,
    input  logic [RFIDX_W-1:0]  i_rdidx0,
    input  logic [XLEN-1:0]     i_rdwdata0,
    input  logic                i_rdwen1,
    input  logic [RFIDX_W-1:0]  i_rdidx1,
    input  logic [XLEN-1:0]     i_rdwdata1,
    input  logic                i_rdwen2,
    input  logic [RFIDX_W-1:0]  i_rdidx2,
    input  logic [XLEN-1:0]     i_rdwdata2,
    input  logic                i_csr_wen,
    input  logic [CSRIDX_W-1:0] i_csridx,
    input  logic [XLEN-1:0]     i_csr_wdata,
    output logic                o_rf_wen,
    output logic [RFIDX_W-1:0]  o_rf_widx,
    output logic [XLEN-1:0]     o_rf_wdata,
    output logic                o_csr_wen,
    output logic [CSRIDX_W-1:0] o_csridx,
    output logic [XLEN-1:0]     o_csr_wdata,
    output logic                o_pend_m_vld,
    output logic [RFIDX_W-1:0]  o_pend_m_idx,
    output logic                o_pend_l_vld,
    output logic [RFIDX_W-1:0]  o_pend_l_idx,
    output logic                o_wb_stall,
    output logic                o_ovf
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic               a0, a1, a2;
    logic               m_vld, l_vld;
    logic [RFIDX_W-1:0] m_idx, l_idx;
    logic [XLEN-1:0]    m_data, l_data;
    logic               age_l_first, age_n;
    logic [STARVE_W-1:0] starve_cnt, starve_n;

    logic               m_raw, l_raw, m_p0, l_p0, ml_same, l_older;
    logic               m_live, l_live, grant_m, grant_l;
    logic [RFIDX_W-1:0] m_cidx, l_cidx;
    logic [XLEN-1:0]    m_cdata, l_cdata;
    logic               m_reload, l_reload, m_fresh, l_fresh;
    logic               m_keep_pre, l_keep_pre, m_late_kill, l_late_kill;
    logic               m_keep, l_keep, m_load, l_load, m_clear, l_clear, m_kill, l_kill;
    logic               m_vld_n, l_vld_n, ovf_evt, stall_n;
    logic               occ, slot_gnt;
    gnt_src_e           gnt;
    logic               rf_wen_n;
    logic [RFIDX_W-1:0] rf_widx_n;
    logic [XLEN-1:0]    rf_wdata_n;

    assign a0 = i_rdwen0 && (i_rdidx0 != '0);
    assign a1 = i_rdwen1 && (i_rdidx1 != '0);
    assign a2 = i_rdwen2 && (i_rdidx2 != '0);

    // A waiting slot entry always stands in for its source; a new arrival only competes when the slot is empty.
    assign m_raw   = m_vld || a1;
    assign l_raw   = l_vld || a2;
    assign m_cidx  = m_vld ? m_idx  : i_rdidx1;
    assign m_cdata = m_vld ? m_data : i_rdwdata1;
    assign l_cidx  = l_vld ? l_idx  : i_rdidx2;
    assign l_cdata = l_vld ? l_data : i_rdwdata2;

    // Two fresh arrivals count as equal age, and on equal age the MDU is treated as the older one.
    assign l_older = l_vld && (!m_vld || age_l_first);
    assign m_p0    = m_raw && !(a0 && (m_cidx == i_rdidx0));
    assign l_p0    = l_raw && !(a0 && (l_cidx == i_rdidx0));
    assign ml_same = m_p0 && l_p0 && (m_cidx == l_cidx);
    assign m_live  = m_p0 && !(ml_same && !l_older);
    assign l_live  = l_p0 && !(ml_same && l_older);

    always_comb begin
        gnt = GNT_NONE;
        if (a0)
            gnt = GNT_P0;
        else if (m_live && (!l_older || !l_live))
            gnt = GNT_MDU;
        else if (l_live)
            gnt = GNT_LSU;
    end

    assign grant_m = (gnt == GNT_MDU);
    assign grant_l = (gnt == GNT_LSU);

    // A refill behind a draining slot is younger than whatever the other slot keeps, so a matching index there dies.
    assign m_reload    = m_vld && a1 && grant_m;
    assign l_reload    = l_vld && a2 && grant_l;
    assign m_fresh     = !m_vld && a1 && m_live && !grant_m;
    assign l_fresh     = !l_vld && a2 && l_live && !grant_l;
    assign m_keep_pre  = m_vld && m_live && !grant_m;
    assign l_keep_pre  = l_vld && l_live && !grant_l;
    assign m_late_kill = l_reload && m_keep_pre && (m_idx == i_rdidx2);
    assign l_late_kill = m_reload && l_keep_pre && (l_idx == i_rdidx1);
    assign m_keep      = m_keep_pre && !m_late_kill;
    assign l_keep      = l_keep_pre && !l_late_kill;
    assign m_load      = m_fresh || m_reload;
    assign l_load      = l_fresh || l_reload;
    assign m_clear     = m_vld && grant_m;
    assign l_clear     = l_vld && grant_l;
    assign m_kill      = (m_vld && !m_live) || m_late_kill;
    assign l_kill      = (l_vld && !l_live) || l_late_kill;
    assign m_vld_n     = m_keep || m_load;
    assign l_vld_n     = l_keep || l_load;
    assign ovf_evt     = (m_vld && a1 && !grant_m) || (l_vld && a2 && !grant_l);

    always_comb begin
        age_n = 1'b0;
        if (m_keep && l_keep)
            age_n = age_l_first;
        else if (l_keep)
            age_n = 1'b1;
    end

    assign occ      = m_vld || l_vld;
    assign slot_gnt = m_clear || l_clear;

    always_comb begin
        starve_n = '0;
        if (occ && !slot_gnt)
            starve_n = (starve_cnt == STARVE_W'(STARVE_MAX)) ? starve_cnt : starve_cnt + STARVE_W'(1);
    end

    assign stall_n = (m_vld_n && l_vld_n) || (starve_n == STARVE_W'(STARVE_MAX))
                  || (m_vld && a2) || (l_vld && a1);

    always_comb begin
        rf_wen_n   = 1'b0;
        rf_widx_n  = '0;
        rf_wdata_n = '0;
        unique case (gnt)
            GNT_P0:  begin rf_wen_n = 1'b1; rf_widx_n = i_rdidx0; rf_wdata_n = i_rdwdata0; end
            GNT_MDU: begin rf_wen_n = 1'b1; rf_widx_n = m_cidx;   rf_wdata_n = m_cdata;    end
            GNT_LSU: begin rf_wen_n = 1'b1; rf_widx_n = l_cidx;   rf_wdata_n = l_cdata;    end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rf_wen    <= 1'b0;
            o_rf_widx   <= '0;
            o_rf_wdata  <= '0;
            o_csr_wen   <= 1'b0;
            o_csridx    <= '0;
            o_csr_wdata <= '0;
            o_wb_stall  <= 1'b0;
            o_ovf       <= 1'b0;
            age_l_first <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            o_rf_wen    <= rf_wen_n;
            o_rf_widx   <= rf_widx_n;
            o_rf_wdata  <= rf_wdata_n;
            o_csr_wen   <= i_csr_wen;
            o_csridx    <= i_csridx;
            o_csr_wdata <= i_csr_wdata;
            o_wb_stall  <= stall_n;
            o_ovf       <= o_ovf || ovf_evt;
            age_l_first <= age_n;
            starve_cnt  <= starve_n;
        end
    end

    wbu_pend_slot #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) u_slot_m (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (m_load),
        .clear     (m_clear),
        .kill      (m_kill),
        .load_idx  (i_rdidx1),
        .load_data (i_rdwdata1),
        .vld       (m_vld),
        .idx       (m_idx),
        .data      (m_data)
    );

    wbu_pend_slot #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) u_slot_l (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (l_load),
        .clear     (l_clear),
        .kill      (l_kill),
        .load_idx  (i_rdidx2),
        .load_data (i_rdwdata2),
        .vld       (l_vld),
        .idx       (l_idx),
        .data      (l_data)
    );

    assign o_pend_m_vld = m_vld;
    assign o_pend_m_idx = m_idx;
    assign o_pend_l_vld = l_vld;
    assign o_pend_l_idx = l_idx;

endmodule

// File: tb/tb_wbu_arbiter.sv
// Scoreboard bench for wbu_arbiter: expected register writes are queued as stimulus is applied.
module tb_wbu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdwen0, rdwen1, rdwen2;
    logic [4:0]  rdidx0, rdidx1, rdidx2;
    logic [31:0] rdwdata0, rdwdata1, rdwdata2;
    logic        csrWen;
    logic [11:0] csrIdx;
    logic [31:0] csrWdata;
    logic        rfWen, csrWenQ, pendMVld, pendLVld, wbStall, ovf;
    logic [4:0]  rfWidx, pendMIdx, pendLIdx;
    logic [31:0] rfWdata, csrWdataQ;
    logic [11:0] csrIdxQ;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;

    wr_t sbQueue[$];
    int  nChecks = 0;
    int  nPass   = 0;

    always #5 clk = ~clk;

    wbu_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rdwen0    (rdwen0),
        .i_rdidx0    (rdidx0),
        .i_rdwdata0  (rdwdata0),
        .i_rdwen1    (rdwen1),
        .i_rdidx1    (rdidx1),
        .i_rdwdata1  (rdwdata1),
        .i_rdwen2    (rdwen2),
        .i_rdidx2    (rdidx2),
        .i_rdwdata2  (rdwdata2),
        .i_csr_wen   (csrWen),
        .i_csridx    (csrIdx),
        .i_csr_wdata (csrWdata),
        .o_rf_wen    (rfWen),
        .o_rf_widx   (rfWidx),
        .o_rf_wdata  (rfWdata),
        .o_csr_wen   (csrWenQ),
        .o_csridx    (csrIdxQ),
        .o_csr_wdata (csrWdataQ),
        .o_pend_m_vld(pendMVld),
        .o_pend_m_idx(pendMIdx),
        .o_pend_l_vld(pendLVld),
        .o_pend_l_idx(pendLIdx),
        .o_wb_stall  (wbStall),
        .o_ovf       (ovf)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic pushWrite(input logic [4:0] idx, input logic [31:0] data);
        wr_t w;
        w.idx  = idx;
        w.data = data;
        sbQueue.push_back(w);
    endtask

    // Drives one cycle of result-port inputs and returns 1ns after the capturing edge.
    task automatic applyStimulus(input logic w0, input logic [4:0] x0, input logic [31:0] d0,
                                 input logic w1, input logic [4:0] x1, input logic [31:0] d1,
                                 input logic w2, input logic [4:0] x2, input logic [31:0] d2);
        rdwen0 = w0; rdidx0 = x0; rdwdata0 = d0;
        rdwen1 = w1; rdidx1 = x1; rdwdata1 = d1;
        rdwen2 = w2; rdidx2 = x2; rdwdata2 = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    endtask

    // Every register-file write the DUT makes must match the head of the expected queue.
    always @(negedge clk) begin
        if (rfWen === 1'b1) begin
            if (sbQueue.size() == 0) begin
                checkOutput("spurious_wen", {63'd0, rfWen}, 64'd0);
            end else begin
                wr_t w;
                w = sbQueue.pop_front();
                checkOutput("wr_idx", {59'd0, rfWidx}, {59'd0, w.idx});
                checkOutput("wr_data", {32'd0, rfWdata}, {32'd0, w.data});
            end
        end
    end

    initial begin
        rst = 1'b1;
        csrWen = 1'b0; csrIdx = '0; csrWdata = '0;
        idleCycle();
        idleCycle();
        checkOutput("rst_wen", {63'd0, rfWen}, 64'd0);
        checkOutput("rst_stall", {63'd0, wbStall}, 64'd0);
        checkOutput("rst_ovf", {63'd0, ovf}, 64'd0);
        checkOutput("rst_pend_m", {63'd0, pendMVld}, 64'd0);
        checkOutput("rst_csr_wen", {63'd0, csrWenQ}, 64'd0);
        rst = 1'b0;

        // Port0 alone, with a CSR write alongside.
        csrWen = 1'b1; csrIdx = 12'h300; csrWdata = 32'hCAFE;
        pushWrite(5'd5, 32'h11);
        applyStimulus(1, 5'd5, 32'h11, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        csrWen = 1'b0;
        checkOutput("p0_wen", {63'd0, rfWen}, 64'd1);
        checkOutput("csr_wen", {63'd0, csrWenQ}, 64'd1);
        checkOutput("csr_idx", {52'd0, csrIdxQ}, 64'h300);
        checkOutput("csr_data", {32'd0, csrWdataQ}, 64'hCAFE);
        idleCycle();
        checkOutput("p0_idle_wen", {63'd0, rfWen}, 64'd0);
        checkOutput("csr_wen_off", {63'd0, csrWenQ}, 64'd0);

        // Port0 beats port1; MDU result waits one cycle.
        pushWrite(5'd3, 32'hA);
        pushWrite(5'd7, 32'hB);
        applyStimulus(1, 5'd3, 32'hA, 1, 5'd7, 32'hB, 0, 5'd0, 32'h0);
        checkOutput("col_pend_m", {63'd0, pendMVld}, 64'd1);
        checkOutput("col_pend_m_idx", {59'd0, pendMIdx}, 64'd7);
        checkOutput("col_stall", {63'd0, wbStall}, 64'd0);
        idleCycle();
        checkOutput("col_drain_wen", {63'd0, rfWen}, 64'd1);
        checkOutput("col_drain_pend", {63'd0, pendMVld}, 64'd0);
        idleCycle();

        // Port0 write to the same index kills the waiting MDU entry.
        pushWrite(5'd9, 32'h1);
        applyStimulus(1, 5'd9, 32'h1, 1, 5'd4, 32'h44, 0, 5'd0, 32'h0);
        checkOutput("waw_pend_set", {63'd0, pendMVld}, 64'd1);
        pushWrite(5'd4, 32'h55);
        applyStimulus(1, 5'd4, 32'h55, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        checkOutput("waw_pend_clr", {63'd0, pendMVld}, 64'd0);
        idleCycle();
        idleCycle();
        checkOutput("waw_no_extra", sbQueue.size(), 64'd0);

        // LSU entry starved by a busy port0 forces a stall, then drains in the bubble.
        pushWrite(5'd1, 32'h100);
        applyStimulus(1, 5'd1, 32'h100, 0, 5'd0, 32'h0, 1, 5'd12, 32'hC0);
        checkOutput("stv_pend_l", {63'd0, pendLVld}, 64'd1);
        for (int k = 1; k <= 4; k++) begin
            pushWrite(5'(k + 1), 32'h200 + 32'(k));
            applyStimulus(1, 5'(k + 1), 32'h200 + 32'(k), 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
            checkOutput($sformatf("stv_stall_%0d", k), {63'd0, wbStall}, (k == 4) ? 64'd1 : 64'd0);
        end
        pushWrite(5'd12, 32'hC0);
        idleCycle();
        checkOutput("stv_bubble_wen", {63'd0, rfWen}, 64'd1);
        checkOutput("stv_stall_drop", {63'd0, wbStall}, 64'd0);
        checkOutput("stv_pend_l_clr", {63'd0, pendLVld}, 64'd0);
        idleCycle();

        // x0 writes are dropped; a second MDU arrival into a full slot overflows.
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0);
        checkOutput("x0_wen", {63'd0, rfWen}, 64'd0);
        checkOutput("x0_pend", {63'd0, pendMVld}, 64'd0);
        pushWrite(5'd6, 32'h6);
        applyStimulus(1, 5'd6, 32'h6, 1, 5'd8, 32'h88, 0, 5'd0, 32'h0);
        checkOutput("ovf_before", {63'd0, ovf}, 64'd0);
        pushWrite(5'd10, 32'h10);
        applyStimulus(1, 5'd10, 32'h10, 1, 5'd11, 32'h99, 0, 5'd0, 32'h0);
        checkOutput("ovf_set", {63'd0, ovf}, 64'd1);
        checkOutput("ovf_slot_idx", {59'd0, pendMIdx}, 64'd8);
        pushWrite(5'd8, 32'h88);
        idleCycle();
        idleCycle();
        checkOutput("ovf_sticky", {63'd0, ovf}, 64'd1);
        checkOutput("ovf_no_extra", sbQueue.size(), 64'd0);

        // Reset with both slots full discards them without writing.
        pushWrite(5'd13, 32'hD);
        applyStimulus(1, 5'd13, 32'hD, 1, 5'd14, 32'hE, 1, 5'd15, 32'hF);
        checkOutput("mid_pend_m", {63'd0, pendMVld}, 64'd1);
        checkOutput("mid_pend_l", {63'd0, pendLVld}, 64'd1);
        checkOutput("mid_stall", {63'd0, wbStall}, 64'd1);
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        checkOutput("mid_rst_wen", {63'd0, rfWen}, 64'd0);
        checkOutput("mid_rst_pend_m", {63'd0, pendMVld}, 64'd0);
        checkOutput("mid_rst_pend_l", {63'd0, pendLVld}, 64'd0);
        checkOutput("mid_rst_stall", {63'd0, wbStall}, 64'd0);
        checkOutput("mid_rst_ovf", {63'd0, ovf}, 64'd0);
        repeat (4) idleCycle();
        checkOutput("final_sb_empty", sbQueue.size(), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
